// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares port A of a 32 x 16-bit, two-byte-lane SRAM among NREQ requesters.
// A combinational round-robin picks one valid requester per cycle; the
// winner's command is registered onto the SRAM port (stage 1) and a small
// tag (winner index + is-read) follows it one stage further (stage 2), so
// read data comes back to the right requester exactly two cycles after the
// accept.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   req_valid/we    : per-requester command valid and write flag (NREQ)
//   req_addr        : packed addresses, requester i at [i*AW +: AW]
//   req_wdata       : packed write data, requester i at [i*DW +: DW]
//   req_be          : packed byte enables, requester i at [i*BEW +: BEW]
//   req_ready       : one-hot grant, command accepted when valid & ready
//   rsp_valid       : one-hot pulse per completed read
//   rsp_rdata       : read data while any rsp_valid bit is set, else 0
//   sram_en/we      : SRAM en_a / we_a
//   sram_byte_en    : SRAM byte_en_a (zero for reads)
//   sram_addr/din   : SRAM addr_a / din_a
//   sram_dout       : SRAM dout_a, registered by the SRAM on a read edge

module sram_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 16,
    parameter int BEW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_we,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_wdata,
    input  logic [NREQ*BEW-1:0] req_be,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic                sram_en,
    output logic                sram_we,
    output logic [BEW-1:0]      sram_byte_en,
    output logic [AW-1:0]       sram_addr,
    output logic [DW-1:0]       sram_din,
    input  logic [DW-1:0]       sram_dout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand_idx;
    logic            win_found;
    logic [NREQ-1:0] grant;
    logic            accept;

    logic            s1_rd;
    logic [IW-1:0]   s1_tag;
    logic            s2_rd;
    logic [IW-1:0]   s2_tag;

    logic [AW-1:0]   cmd_addr  [NREQ];
    logic [DW-1:0]   cmd_wdata [NREQ];
    logic [BEW-1:0]  cmd_be    [NREQ];

    // Unpack the flat per-requester buses so the winner can be indexed directly.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign cmd_addr[g]  = req_addr[g*AW +: AW];
        assign cmd_wdata[g] = req_wdata[g*DW +: DW];
        assign cmd_be[g]    = req_be[g*BEW +: BEW];
    end

    // Round-robin search: walk NREQ candidates starting just after the last
    // winner, so last_grant itself is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        grant     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = IW'((int'(last_grant) + k) % NREQ);
            if (!win_found && req_valid[cand_idx]) begin
                win_found       = 1'b1;
                win_idx         = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

    // Grants are suppressed while reset is held.
    assign req_ready = rst ? '0 : grant;
    assign accept    = win_found && !rst;

    // Stage 1 registers the winning command onto the SRAM port; stage 2 only
    // carries the tag so it lines up with the SRAM's registered read data.
    // Address, data and byte enables hold on idle cycles; only en/we drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= IW'(NREQ - 1);
            sram_en      <= 1'b0;
            sram_we      <= 1'b0;
            sram_byte_en <= '0;
            sram_addr    <= '0;
            sram_din     <= '0;
            s1_rd        <= 1'b0;
            s1_tag       <= '0;
            s2_rd        <= 1'b0;
            s2_tag       <= '0;
        end else begin
            s2_rd  <= s1_rd;
            s2_tag <= s1_tag;
            if (accept) begin
                last_grant   <= win_idx;
                sram_en      <= 1'b1;
                sram_we      <= req_we[win_idx];
                sram_byte_en <= req_we[win_idx] ? cmd_be[win_idx] : '0;
                sram_addr    <= cmd_addr[win_idx];
                sram_din     <= cmd_wdata[win_idx];
                s1_rd        <= !req_we[win_idx];
                s1_tag       <= win_idx;
            end else begin
                sram_en <= 1'b0;
                sram_we <= 1'b0;
                s1_rd   <= 1'b0;
            end
        end
    end

    // The SRAM has already registered dout by the time the tag reaches
    // stage 2, so the data is passed straight through to the requester.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (s2_rd) begin
            rsp_valid[s2_tag] = 1'b1;
            rsp_rdata         = sram_dout;
        end
    end

endmodule
